// File: rtl/jk_cmd_sched.sv
// rtl/jk_cmd_sched.sv - two-requester command scheduler driving a JK flip-flop
//
// Accepts timed J/K commands from two requesters, arbitrates round-robin on ties,
// drives the opcode onto j/k for exactly cnt cycles, then pulses done and captures
// the flip-flop's Q.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req0_valid   requester 0 command pending
//   req0_op      requester 0 opcode (00 hold, 01 reset, 10 set, 11 toggle)
//   req0_cnt     requester 0 number of cycles to drive the opcode
//   req0_ready   requester 0 command accepted this cycle (combinational)
//   req1_*       same for requester 1
//   q_in         Q fed back from the controlled JK flip-flop
//   j, k         registered J/K drive
//   busy         state is not IDLE
//   done         single-cycle completion pulse
//   grant_id     requester owning the current or most recent command
//   q_final      q_in captured when the most recent command completed
module jk_cmd_sched #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [CNT_W-1:0] req0_cnt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [CNT_W-1:0] req1_cnt,
  output logic             req1_ready,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             grant_id,
  output logic             q_final
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             last_grant, last_nxt;
  logic             j_nxt, k_nxt, grant_nxt, qf_nxt;
  logic [1:0]       op_sel;
  logic             win0, win1;

  // On a tie the requester that did not win last time gets the grant.
  assign win0 = req0_valid && (!req1_valid || last_grant);
  assign win1 = req1_valid && !win0;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt_r      <= '0;
      j          <= 1'b0;
      k          <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      q_final    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt_r      <= cnt_nxt;
      j          <= j_nxt;
      k          <= k_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      q_final    <= qf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_r;
    j_nxt      = 1'b0;
    k_nxt      = 1'b0;
    grant_nxt  = grant_id;
    last_nxt   = last_grant;
    qf_nxt     = q_final;
    op_sel     = 2'b00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = win0;
        req1_ready = win1;
        if (win0 || win1) begin
          grant_nxt = win1;
          last_nxt  = win1;
          cnt_nxt   = win1 ? req1_cnt : req0_cnt;
          op_sel    = win1 ? req1_op : req0_op;
          if (cnt_nxt != '0) begin
            state_nxt = DRIVE;
            j_nxt     = op_sel[1];
            k_nxt     = op_sel[0];
          end else begin
            // Zero-length command: skip straight to completion, j/k stay low.
            state_nxt = DONE;
          end
        end
      end
      DRIVE: begin
        cnt_nxt = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt = DONE;
        end else begin
          j_nxt = j;
          k_nxt = k;
        end
      end
      DONE: begin
        qf_nxt    = q_in;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jk_cmd_sched.sv
// tb/tb_jk_cmd_sched.sv - randomized self-checking bench for jk_cmd_sched
module tb_jk_cmd_sched;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [1:0]       req0_op, req1_op;
  logic [CNT_W-1:0] req0_cnt, req1_cnt;
  logic             req0_ready, req1_ready;
  logic             q_in, j, k, busy, done, grant_id, q_final;

  jk_cmd_sched #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_cnt   (req0_cnt),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_cnt   (req1_cnt),
    .req1_ready (req1_ready),
    .q_in       (q_in),
    .j          (j),
    .k          (k),
    .busy       (busy),
    .done       (done),
    .grant_id   (grant_id),
    .q_final    (q_final)
  );

  always #5 clk = ~clk;

  // The JK flip-flop being controlled.
  logic q = 1'b0;
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end
  assign q_in = q;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic new_cmd(input int r);
    logic [1:0]       op;
    logic [CNT_W-1:0] cn;
    int               sel;
    op  = 2'($urandom_range(0, 3));
    sel = $urandom_range(0, 4);
    if (sel == 0)      cn = '0;
    else if (sel == 1) cn = '1;
    else               cn = CNT_W'($urandom_range(1, (1 << CNT_W) - 2));
    if (r == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_cnt = cn;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_cnt = cn;
    end
  endtask

  // Transaction-level model: each accepted command occupies a window of
  // cycles [s+1, s+cnt] driving op, cycle s+cnt+1 is the done cycle, and the
  // scheduler is free to accept again from cycle s+cnt+2.
  int         c, s, m_cnt, done_cyc, free_at;
  logic [1:0] m_op;
  logic       m_last, m_grant, m_qf;
  logic       acc0, acc1, did_rst, first0;
  logic       e_r0, e_r1, w;

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_cnt = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_cnt = '0;
    #2;
    check("rst_j", j, 0);
    check("rst_k", k, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_grant", grant_id, 0);
    check("rst_qfinal", q_final, 0);
    check("rst_ready0", req0_ready, 0);
    // Tie straight out of reset: req0 set for 3, req1 toggle for 4.
    req0_valid = 1'b1; req0_op = 2'b10; req0_cnt = 4'd3;
    req1_valid = 1'b1; req1_op = 2'b11; req1_cnt = 4'd4;
    #5;
    reset = 1'b1;
    c = 0; s = -10; m_cnt = 0; done_cyc = -1; free_at = 0; m_op = 2'b00;
    m_last = 1'b1; m_grant = 1'b0; m_qf = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0; did_rst = 1'b0; first0 = 1'b1;

    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      check("grant_id", grant_id, m_grant);
      check("q_final", q_final, m_qf);
      check("ready_excl", req0_ready & req1_ready, 0);
      if (c >= free_at) begin
        e_r0 = req0_valid && (!req1_valid || m_last);
        e_r1 = req1_valid && !e_r0;
        check("idle_busy", busy, 0);
        check("idle_j", j, 0);
        check("idle_k", k, 0);
        check("idle_done", done, 0);
        check("ready0", req0_ready, e_r0);
        check("ready1", req1_ready, e_r1);
        if (e_r0 || e_r1) begin
          w        = e_r1;
          s        = c;
          m_cnt    = w ? int'(req1_cnt) : int'(req0_cnt);
          m_op     = w ? req1_op : req0_op;
          done_cyc = c + m_cnt + 1;
          free_at  = c + m_cnt + 2;
          m_last   = w;
          m_grant  = w;
          acc0     = !w;
          acc1     = w;
        end
      end else begin
        check("busy", busy, 1);
        check("busy_ready0", req0_ready, 0);
        check("busy_ready1", req1_ready, 0);
        if (c < done_cyc) begin
          check("drive_j", j, m_op[1]);
          check("drive_k", k, m_op[0]);
          check("drive_done", done, 0);
        end else begin
          check("done_j", j, 0);
          check("done_k", k, 0);
          check("done_pulse", done, 1);
          m_qf = q;
        end
      end

      @(posedge clk);
      #1;
      c++;
      if (acc0) begin
        req0_valid = 1'b0;
        if (first0) begin
          // Long set command waits behind req1's toggle command.
          req0_valid = 1'b1; req0_op = 2'b10; req0_cnt = '1;
          first0 = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          new_cmd(0);
        end
        acc0 = 1'b0;
      end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
        new_cmd(0);
      end
      if (acc1) begin
        req1_valid = 1'b0;
        if ($urandom_range(0, 2) != 0) new_cmd(1);
        acc1 = 1'b0;
      end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
        new_cmd(1);
      end

      // Abort a long command in its second drive cycle.
      if (!did_rst && c > 40 && c == s + 2 && m_cnt >= 5) begin
        reset = 1'b0;
        #1;
        check("abort_j", j, 0);
        check("abort_k", k, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_grant", grant_id, 0);
        check("abort_qfinal", q_final, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        c++;
        did_rst  = 1'b1;
        free_at  = c;
        done_cyc = -1;
        m_last   = 1'b1;
        m_grant  = 1'b0;
        m_qf     = 1'b0;
        new_cmd(0);
        new_cmd(1);
      end
    end

    check("abort_seen", did_rst, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
